// File: rtl/sayac_sel_arbiter8.sv
// sayac_sel_arbiter8: round-robin one-hot select for the SAYAC 16-bit 8-to-1 result mux
// Optional hold timeout with forced hand-off: define SAYAC_ARB_TIMEOUT_EN.
// sel bit 7 is source 1 and bit 0 is source 8; grant_idx = 7 - bit position.
module sayac_sel_arbiter8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_req,
   output logic [7:0] o_sel,
   output logic       o_grant_valid,
   output logic [2:0] o_grant_idx,
   output logic       o_preempt
);
   typedef enum logic {S_IDLE, S_GRANT} state_t;
   state_t     r_state;
   logic [2:0] r_ptr;
   logic [7:0] r_sel;
   logic       r_valid;
   logic [2:0] r_idx;
   logic [2:0] w_g;
   logic       w_hold;
   logic       w_to;
   logic       w_keep;
   logic [3:0] w_nxt;
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("MAX_HOLD must be in 2..255");
   end
   // first requesting bit scanning downward from ptr with wrap; {found, bit}
   function automatic logic [3:0] f_pick(input logic [7:0] req, input logic [2:0] ptr);
      logic [2:0] b;
      f_pick = 4'b0;
      for (int k = 7; k >= 0; k--) begin
         b = ptr - 3'(k);
         if (req[b]) f_pick = {1'b1, b};
      end
   endfunction
   assign w_g    = ~r_idx;
   assign w_hold = (r_state == S_GRANT) && i_req[w_g];
`ifdef SAYAC_ARB_TIMEOUT_EN
   logic [7:0] r_hold_cnt;
   logic       r_preempt;
   logic [7:0] w_others;
   assign w_others  = i_req & ~(8'd1 << w_g);
   assign w_to      = w_hold && (r_hold_cnt == 8'(MAX_HOLD - 1)) && (|w_others);
   assign w_nxt     = w_to ? f_pick(w_others, r_ptr) : f_pick(i_req, r_ptr);
   assign o_preempt = r_preempt;
`else
   assign w_to      = 1'b0;
   assign w_nxt     = f_pick(i_req, r_ptr);
   assign o_preempt = 1'b0;
`endif
   assign w_keep = w_hold && !w_to;
   // FSM: hold the current grant, hand off to the next winner, or go idle
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= 3'd7;
         r_sel   <= 8'h00;
         r_valid <= 1'b0;
         r_idx   <= 3'd0;
`ifdef SAYAC_ARB_TIMEOUT_EN
         r_hold_cnt <= 8'd0;
         r_preempt  <= 1'b0;
`endif
      end else if (w_keep) begin
`ifdef SAYAC_ARB_TIMEOUT_EN
         r_hold_cnt <= (r_hold_cnt == 8'(MAX_HOLD - 1)) ? r_hold_cnt : r_hold_cnt + 8'd1;
         r_preempt  <= 1'b0;
`endif
      end else if (w_nxt[3]) begin
         r_state <= S_GRANT;
         r_ptr   <= w_nxt[2:0] - 3'd1;
         r_sel   <= 8'd1 << w_nxt[2:0];
         r_valid <= 1'b1;
         r_idx   <= ~w_nxt[2:0];
`ifdef SAYAC_ARB_TIMEOUT_EN
         r_hold_cnt <= 8'd0;
         r_preempt  <= w_to;
`endif
      end else begin
         r_state <= S_IDLE;
         r_sel   <= 8'h00;
         r_valid <= 1'b0;
         r_idx   <= 3'd0;
`ifdef SAYAC_ARB_TIMEOUT_EN
         r_hold_cnt <= 8'd0;
         r_preempt  <= 1'b0;
`endif
      end
   assign o_sel         = r_sel;
   assign o_grant_valid = r_valid;
   assign o_grant_idx   = r_idx;
endmodule

// File: tb/tb_sayac_sel_arbiter8.sv
// tb_sayac_sel_arbiter8: scenario tasks checked against a source-rotation reference model
module tb_sayac_sel_arbiter8;
   localparam int MH = 4;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'h00;
   logic [7:0] sel;
   logic       gv;
   logic [2:0] gi;
   logic       pre;
   int tests = 0;
   int fails = 0;
   // model: holder and last winner as source numbers 1..8 (0 = none)
   int m_hold, m_last, m_n;
   logic m_pre;
   always #5 clk = ~clk;
   sayac_sel_arbiter8 #(.MAX_HOLD(MH)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
      .o_sel(sel), .o_grant_valid(gv), .o_grant_idx(gi), .o_preempt(pre)
   );
   function automatic logic [7:0] src_bit(input int s);
      return (s == 0) ? 8'h00 : (8'h80 >> (s - 1));
   endfunction
   function automatic int next_src(input logic [7:0] r, input int last);
      int s;
      for (int k = 1; k <= 8; k++) begin
         s = (last - 1 + k) % 8 + 1;
         if ((r & src_bit(s)) != 0) return s;
      end
      return 0;
   endfunction
   function automatic logic [12:0] m_vec();
      return {src_bit(m_hold), m_hold != 0, (m_hold != 0) ? 3'(m_hold - 1) : 3'd0, m_pre};
   endfunction
   task automatic model_reset();
      m_hold = 0; m_last = 8; m_n = 0; m_pre = 1'b0;
   endtask
   task automatic model_step(input logic [7:0] r);
      int w;
      m_pre = 1'b0;
      if (m_hold != 0 && (r & src_bit(m_hold)) != 0) begin
`ifdef SAYAC_ARB_TIMEOUT_EN
         if (m_n >= MH && (r & ~src_bit(m_hold)) != 0) begin
            w = next_src(r & ~src_bit(m_hold), m_last);
            m_hold = w; m_last = w; m_n = 1; m_pre = 1'b1;
         end else m_n++;
`else
         m_n++;
`endif
      end else begin
         w = next_src(r, m_last);
         m_hold = w;
         if (w != 0) begin m_last = w; m_n = 1; end
      end
   endtask
   // called at a negedge; applies r, lets one rising edge pass, returns at next negedge
   task automatic step(input logic [7:0] r);
      req = r;
      @(posedge clk);
      model_step(r);
      @(negedge clk);
   endtask
   task automatic do_reset();
      rst_n = 1'b0; req = 8'h00; model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_reset();
      rst_n = 1'b0; req = 8'hFF; model_reset();
      @(negedge clk);
      tests++;
      if ({sel, gv, gi, pre} !== 13'd0) begin
         fails++;
         $display("FAIL reset: got sel=%h gv=%b idx=%0d pre=%b, want all zero", sel, gv, gi, pre);
      end
      rst_n = 1'b1; req = 8'h00;
   endtask
   task automatic test_priority();
      logic [7:0] e;
      do_reset();
      step(8'hFF);
      tests++;
      if (sel !== 8'h80 || gi !== 3'd0 || {sel, gv, gi, pre} !== m_vec()) begin
         fails++; $display("FAIL prio_first: got sel=%h idx=%0d, want sel=80 idx=0", sel, gi);
      end
      step(8'h7F);
      tests++;
      if (sel !== 8'h40 || gi !== 3'd1 || {sel, gv, gi, pre} !== m_vec()) begin
         fails++; $display("FAIL prio_handoff: got sel=%h idx=%0d, want sel=40 idx=1", sel, gi);
      end
      for (int k = 2; k <= 9; k++) begin
         step(8'hFF & ~src_bit(m_hold));
         e = 8'h80 >> (k % 8);
         tests++;
         if (sel !== e || {sel, gv, gi, pre} !== m_vec()) begin
            fails++; $display("FAIL prio_rotate[%0d]: got sel=%h, want %h", k, sel, e);
         end
      end
   endtask
   task automatic test_single();
      do_reset();
      step(8'h00);
      tests++;
      if (sel !== 8'h00 || gv !== 1'b0) begin
         fails++; $display("FAIL single_idle: got sel=%h gv=%b, want 00 0", sel, gv);
      end
      for (int k = 0; k < 3; k++) begin
         step(8'h01);
         tests++;
         if (sel !== 8'h01 || gi !== 3'd7 || gv !== 1'b1) begin
            fails++; $display("FAIL single_hold[%0d]: got sel=%h idx=%0d, want 01 7", k, sel, gi);
         end
      end
      step(8'h00);
      tests++;
      if ({sel, gv, gi, pre} !== 13'd0) begin
         fails++; $display("FAIL single_release: got sel=%h gv=%b idx=%0d, want 00 0 0", sel, gv, gi);
      end
      step(8'h01);
      tests++;
      if (sel !== 8'h01) begin
         fails++; $display("FAIL single_regrant: got sel=%h, want 01", sel);
      end
   endtask
   task automatic test_wrap();
      do_reset();
      step(8'h01);
      step(8'h00);
      step(8'h81);
      tests++;
      if (sel !== 8'h80 || {sel, gv, gi, pre} !== m_vec()) begin
         fails++; $display("FAIL wrap: got sel=%h, want 80", sel);
      end
   endtask
   task automatic test_async_reset();
      do_reset();
      step(8'h20);
      tests++;
      if (sel !== 8'h20) begin
         fails++; $display("FAIL areset_pre: got sel=%h, want 20", sel);
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      tests++;
      if (sel !== 8'h00 || gv !== 1'b0 || gi !== 3'd0) begin
         fails++; $display("FAIL areset_mid: got sel=%h gv=%b idx=%0d, want 00 0 0", sel, gv, gi);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(8'h21);
      tests++;
      if (sel !== 8'h20 || {sel, gv, gi, pre} !== m_vec()) begin
         fails++; $display("FAIL areset_after: got sel=%h, want 20", sel);
      end
   endtask
   task automatic test_timeout();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         step(8'h88);
         tests++;
         if (sel !== 8'h80 || pre !== 1'b0) begin
            fails++; $display("FAIL to_hold[%0d]: got sel=%h pre=%b, want 80 0", k, sel, pre);
         end
      end
      step(8'h88);
      tests++;
`ifdef SAYAC_ARB_TIMEOUT_EN
      if (sel !== 8'h08 || pre !== 1'b1) begin
         fails++; $display("FAIL to_preempt: got sel=%h pre=%b, want 08 1", sel, pre);
      end
`else
      if (sel !== 8'h80 || pre !== 1'b0) begin
         fails++; $display("FAIL to_nopreempt: got sel=%h pre=%b, want 80 0", sel, pre);
      end
`endif
      for (int k = 0; k < 100; k++) begin
         step(8'h88);
         tests++;
         if ({sel, gv, gi, pre} !== m_vec()) begin
            fails++; $display("FAIL to_long[%0d]: got sel=%h pre=%b, want sel=%h pre=%b", k, sel, pre, src_bit(m_hold), m_pre);
         end
      end
      do_reset();
      for (int k = 0; k < 30; k++) begin
         step(8'h80);
         tests++;
         if (sel !== 8'h80 || pre !== 1'b0) begin
            fails++; $display("FAIL to_alone[%0d]: got sel=%h pre=%b, want 80 0", k, sel, pre);
         end
      end
   endtask
   task automatic test_random();
      logic [7:0] r = 8'h00;
      do_reset();
      for (int k = 0; k < 600; k++) begin
         r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         if ($urandom_range(0, 19) == 0) r = 8'($urandom);
         step(r);
         tests++;
         if ({sel, gv, gi, pre} !== m_vec()) begin
            fails++;
            $display("FAIL random[%0d] req=%h: got sel=%h gv=%b idx=%0d pre=%b, want sel=%h pre=%b",
                     k, r, sel, gv, gi, pre, src_bit(m_hold), m_pre);
         end
      end
   endtask
   initial begin
      model_reset();
      @(negedge clk);
      test_reset();
      test_priority();
      test_single();
      test_wrap();
      test_async_reset();
      test_timeout();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
